// File: rtl/serial_sub_nbit.sv
// Bit-serial ripple-borrow subtractor: D = X - Y - BIN, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow register are reused across N SHIFT cycles.
module serial_sub_nbit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  xs_q, xs_d;
  logic [N-1:0]  ys_q, ys_d;
  logic [N-1:0]  res_q, res_d;
  logic          b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Operand sign bits are kept apart because xs/ys lose them while shifting.
  logic          xm_q, xm_d;
  logic          ym_q, ym_d;
  logic [N-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;

  logic          xi, yi, di, b_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      res_q   <= '0;
      b_q     <= 1'b0;
      cnt_q   <= '0;
      xm_q    <= 1'b0;
      ym_q    <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      res_q   <= res_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Full-subtractor cell shared by every bit position.
  assign xi   = xs_q[0];
  assign yi   = ys_q[0];
  assign di   = xi ^ yi ^ b_q;
  assign b_nx = (~xi & yi) | (~(xi ^ yi) & b_q);

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    res_d   = res_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          xs_d    = x;
          ys_d    = y;
          b_d     = bin;
          xm_d    = x[N-1];
          ym_d    = y[N-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = {di, res_q[N-1:1]};
        xs_d  = xs_q >> 1;
        ys_d  = ys_q >> 1;
        b_d   = b_nx;
        if (cnt_q == LAST) begin
          d_d     = {di, res_q[N-1:1]};
          bout_d  = b_nx;
          ovf_d   = (xm_q ^ ym_q) & (di ^ xm_q);
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Directed testbench for serial_sub_nbit (N=4): expected values are hand-computed.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_sub_nbit;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;

  int checks;
  int errors;

  serial_sub_nbit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sits on a falling edge. Returns with the bench on the falling edge where done is high.
  task automatic issue_op(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic ba,
                          output int lat, output int busy_cnt);
    x = xa; y = ya; bin = ba; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = ~xa; y = ~ya; bin = ~ba;
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string name, input logic [N-1:0] ed, input logic eb, input logic eo);
    checks++;
    if (d !== ed || bout !== eb || ovf !== eo) begin
      errors++;
      $display("FAIL %s: got d=%h bout=%b ovf=%b expected d=%h bout=%b ovf=%b",
               name, d, bout, ovf, ed, eb, eo);
    end else
      $display("op %s: d=%h bout=%b ovf=%b", name, d, bout, ovf);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    #1;
    checks++;
    if ({busy, done, d, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b d=%h bout=%b ovf=%b expected all 0",
               busy, done, d, bout, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    issue_op(4'd7, 4'd3, 1'b0, lat, bc);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL latency: got %0d expected 4", lat);
    end
    checks++;
    if (bc !== 4) begin
      errors++;
      $display("FAIL busy_len: got %0d expected 4", bc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: got %b expected 0", busy);
    end
    check_result("7-3", 4'h4, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || d !== 4'h4) begin
      errors++;
      $display("FAIL done_pulse_hold: got done=%b d=%h expected done=0 d=4", done, d);
    end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    int lat, bc;
    issue_op(4'd3, 4'd9, 1'b0, lat, bc);
    check_result("3-9", 4'hA, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    issue_op(4'd0, 4'd0, 1'b1, lat, bc);
    check_result("0-0-1", 4'hF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    issue_op(4'hF, 4'h0, 1'b1, lat, bc);
    check_result("F-0-1", 4'hE, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue_op(4'd8, 4'd1, 1'b0, lat, bc);
    check_result("8-1", 4'h7, 1'b0, 1'b1);
    @(negedge clk);
    issue_op(4'd5, 4'd5, 1'b0, lat, bc);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL b2b_latency: got %0d expected 4", lat);
    end
    check_result("5-5", 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int dones;
    logic [N-1:0] d_at_done;
    dones = 0;
    d_at_done = 'x;
    x = 4'd6; y = 4'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 4'hF; y = 4'hF; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) begin
        dones++;
        d_at_done = d;
      end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d expected 1", dones);
    end
    checks++;
    if (d_at_done !== 4'h4) begin
      errors++;
      $display("FAIL ignore_result: got d=%h expected 4", d_at_done);
    end else
      $display("op 6-2 with ignored start: d=%h dones=%0d", d_at_done, dones);
  endtask

  task automatic test_abort();
    int lat, bc, dones;
    dones = 0;
    x = 4'hF; y = 4'h1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, d, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b d=%h bout=%b ovf=%b expected all 0",
               busy, done, d, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", dones);
    end
    issue_op(4'd2, 4'd1, 1'b0, lat, bc);
    check_result("2-1 after abort", 4'h1, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
